// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter, fixed-latency video fetch over posted CPU writes and stalled CPU reads
module vram_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 64
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              vid_rd,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_starve,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic              wb_valid_q, wb_valid_d, rd_pending_q, rd_pending_d;
  logic [ADDR_W-1:0] wb_addr_q, rd_addr_q;
  logic [DATA_W-1:0] wb_data_q, vid_data_q, cpu_rdata_q;
  logic              vid_s1_q, vid_valid_q, rd_s1_q, cpu_rvalid_q, starve_q;
  logic [CW-1:0]     starve_cnt_q, starve_cnt_d;
  logic              acc, drain, rd_issue, blocked;
  assign cpu_busy = rd_pending_q | (wb_valid_q & vid_rd);
  assign acc      = cpu_req & ~cpu_busy;
  assign drain    = wb_valid_q & ~vid_rd;
  // an in-flight read (rd_s1_q) keeps rd_pending set but must not reissue
  assign rd_issue = rd_pending_q & ~rd_s1_q & ~vid_rd & ~wb_valid_q;
  assign blocked  = (wb_valid_q | rd_pending_q) & vid_rd;
  assign wb_valid_d   = (acc & cpu_we) | (wb_valid_q & ~drain);
  assign rd_pending_d = (acc & ~cpu_we) | (rd_pending_q & ~rd_s1_q);
  assign starve_cnt_d = !blocked ? '0 :
                        (starve_cnt_q == CW'(STARVE_MAX)) ? starve_cnt_q : starve_cnt_q + 1'b1;
  assign ram_addr   = vid_rd ? vid_addr : drain ? wb_addr_q : rd_issue ? rd_addr_q : vid_addr;
  assign ram_we     = drain;
  assign ram_wdata  = wb_data_q;
  assign vid_data   = vid_data_q;
  assign vid_valid  = vid_valid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_starve = starve_q;
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
      vid_s1_q     <= 1'b0;
      vid_valid_q  <= 1'b0;
      vid_data_q   <= '0;
      rd_s1_q      <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      vid_s1_q     <= vid_rd;
      vid_valid_q  <= vid_s1_q;
      if (vid_s1_q) vid_data_q <= ram_rdata;
      rd_s1_q      <= rd_issue;
      cpu_rvalid_q <= rd_s1_q;
      if (rd_s1_q) cpu_rdata_q <= ram_rdata;
      wb_valid_q   <= wb_valid_d;
      if (acc & cpu_we) begin
        wb_addr_q <= cpu_addr;
        wb_data_q <= cpu_wdata;
      end
      rd_pending_q <= rd_pending_d;
      if (acc & ~cpu_we) rd_addr_q <= cpu_addr;
      starve_cnt_q <= starve_cnt_d;
      if (starve_cnt_d == CW'(STARVE_MAX)) starve_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of vram_arbiter against a behavioural 8 KB RAM
module tb_vram_arbiter;
  logic        pixel_clock = 1'b0;
  logic        reset = 1'b1;
  logic        vid_rd = 1'b0;
  logic [12:0] vid_addr = '0;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_busy;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_starve;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        pl_we = 1'b0;
  logic [12:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [7:0]  mem [0:8191];
  int total = 0;
  int bad = 0;

  always #5 pixel_clock = ~pixel_clock;

  vram_arbiter dut (
    .pixel_clock(pixel_clock), .reset(reset),
    .vid_rd(vid_rd), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_starve(cpu_starve),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM with one-cycle read latency; pl_* preloads it while the DUT is held in reset
  always @(posedge pixel_clock) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change at the falling edge; checks run 1 ns later, far from the rising edge
  task automatic cyc();
    @(negedge pixel_clock);
  endtask

  task automatic preload(input logic [12:0] a, input logic [7:0] d);
    cyc();
    pl_we = 1'b1;
    pl_addr = a;
    pl_data = d;
    cyc();
    pl_we = 1'b0;
  endtask

  task automatic idle();
    vid_rd = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_vvalid"}, vid_valid, 0);
    chk({tag, "_vdata"}, vid_data, 0);
    chk({tag, "_rdata"}, cpu_rdata, 0);
    chk({tag, "_rvalid"}, cpu_rvalid, 0);
    chk({tag, "_starve"}, cpu_starve, 0);
    chk({tag, "_busy"}, cpu_busy, 0);
    chk({tag, "_we"}, ram_we, 0);
  endtask

  initial begin
    preload(13'h0000, 8'h11);
    preload(13'h0001, 8'h22);
    preload(13'h0002, 8'h33);
    for (int k = 0; k < 10; k++) preload(13'h0200 + 13'(k), 8'h40 + 8'(k));
    preload(13'h0800, 8'hC3);
    preload(13'h0801, 8'h3C);
    preload(13'h0005, 8'h77);
    preload(13'h1FFF, 8'h9E);
    cyc();
    reset = 1'b0;
    #1;
    chk_reset_state("rst");

    // three back-to-back video fetches
    for (int c = 0; c < 6; c++) begin
      cyc();
      vid_rd = c < 3;
      vid_addr = 13'(c < 3 ? c : 0);
      #1;
      chk($sformatf("v3_we_%0d", c), ram_we, 0);
      chk($sformatf("v3_valid_%0d", c), vid_valid, (c >= 2 && c <= 4));
      if (c >= 2 && c <= 4) chk($sformatf("v3_data_%0d", c), vid_data, 32'h11 * (c - 1));
    end

    // write then read-back with no video traffic
    cyc(); idle(); cpu_req = 1; cpu_we = 1; cpu_addr = 13'h1234; cpu_wdata = 8'hA5; #1;
    chk("wr_busy0", cpu_busy, 0);
    cyc(); cpu_we = 0; #1;
    chk("wr_drain_we", ram_we, 1);
    chk("wr_drain_addr", ram_addr, 13'h1234);
    chk("wr_drain_data", ram_wdata, 8'hA5);
    chk("rd_accept_busy", cpu_busy, 0);
    cyc(); idle(); #1;
    chk("rd_issue_we", ram_we, 0);
    chk("rd_issue_addr", ram_addr, 13'h1234);
    chk("rd_issue_busy", cpu_busy, 1);
    cyc(); #1;
    chk("rd_wait_rvalid", cpu_rvalid, 0);
    chk("rd_wait_busy", cpu_busy, 1);
    cyc(); #1;
    chk("rd_rvalid", cpu_rvalid, 1);
    chk("rd_rdata", cpu_rdata, 8'hA5);
    chk("rd_done_busy", cpu_busy, 0);
    cyc(); #1;
    chk("rd_rvalid_pulse", cpu_rvalid, 0);

    // posted write held off by 10 cycles of video
    for (int c = 0; c < 12; c++) begin
      cyc();
      vid_rd = c < 10;
      vid_addr = 13'h0200 + 13'(c < 10 ? c : 0);
      cpu_req = c == 0;
      cpu_we = 1;
      cpu_addr = 13'h0100;
      cpu_wdata = 8'h5A;
      #1;
      chk($sformatf("wb_busy_%0d", c), cpu_busy, (c >= 1 && c <= 9));
      chk($sformatf("wb_we_%0d", c), ram_we, c == 10);
      if (c == 10) chk("wb_addr", ram_addr, 13'h0100);
      if (c >= 2) begin
        chk($sformatf("wb_vvalid_%0d", c), vid_valid, 1);
        chk($sformatf("wb_vdata_%0d", c), vid_data, 8'h40 + 8'(c - 2));
      end
    end
    cyc(); idle(); #1;
    chk("wb_vvalid_end", vid_valid, 0);

    // same-cycle video fetch and CPU read
    cyc(); vid_rd = 1; vid_addr = 13'h0800; cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0801; #1;
    chk("same_addr0", ram_addr, 13'h0800);
    chk("same_busy0", cpu_busy, 0);
    cyc(); idle(); #1;
    chk("same_issue_addr", ram_addr, 13'h0801);
    chk("same_busy1", cpu_busy, 1);
    cyc(); #1;
    chk("same_vvalid", vid_valid, 1);
    chk("same_vdata", vid_data, 8'hC3);
    chk("same_rvalid2", cpu_rvalid, 0);
    cyc(); #1;
    chk("same_rvalid3", cpu_rvalid, 1);
    chk("same_rdata", cpu_rdata, 8'h3C);
    chk("same_vvalid3", vid_valid, 0);

    // starvation: read blocked by 70 cycles of video
    for (int c = 0; c < 75; c++) begin
      cyc();
      vid_rd = c < 70;
      vid_addr = 13'h0000;
      cpu_req = c == 0;
      cpu_we = 0;
      cpu_addr = 13'h0005;
      #1;
      if (c == 0 || c == 64) chk($sformatf("stv_low_%0d", c), cpu_starve, 0);
      if (c == 65 || c == 70 || c == 74) chk($sformatf("stv_high_%0d", c), cpu_starve, 1);
      if (c == 69) chk("stv_busy", cpu_busy, 1);
      if (c == 70) chk("stv_issue_addr", ram_addr, 13'h0005);
      if (c == 71 || c == 73) chk($sformatf("stv_rvalid_lo_%0d", c), cpu_rvalid, 0);
      if (c == 72) begin
        chk("stv_rvalid", cpu_rvalid, 1);
        chk("stv_rdata", cpu_rdata, 8'h77);
      end
    end

    // reset while a read is in flight
    cyc(); idle(); cpu_req = 1; cpu_addr = 13'h1FFF; #1;
    cyc(); idle(); #1;
    chk("rr_issue_addr", ram_addr, 13'h1FFF);
    cyc(); reset = 1; #1;
    for (int c = 0; c < 4; c++) begin
      cyc(); reset = 0; #1;
      chk_reset_state($sformatf("rr_%0d", c));
    end
    cyc(); cpu_req = 1; cpu_we = 0; cpu_addr = 13'h1FFF; #1;
    chk("rr2_busy0", cpu_busy, 0);
    cyc(); idle(); #1;
    chk("rr2_issue", ram_addr, 13'h1FFF);
    cyc(); #1;
    chk("rr2_rvalid_lo", cpu_rvalid, 0);
    cyc(); #1;
    chk("rr2_rvalid", cpu_rvalid, 1);
    chk("rr2_rdata", cpu_rdata, 8'h9E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
